// File: rtl/zap_writeback_mp.sv
// zap_writeback_mp
//   Writeback stage for the ZAP core. It owns PC and CPSR, takes exceptions
//   (vector, mode change, banked R14 + SPSR writes) and drives NWP (1 or 2)
//   register-file write ports. With NWP=1, dual writes (exception R14+SPSR,
//   ALU result + load) are serialised over two cycles, with o_stall back-pressure.
//
//   Optional feature macro: ZAP_WB_HIVEC_EN. When it is defined, i_hivec selects
//   HIVEC_BASE as the vector base. When it is undefined, the base is 0.
//
//   Physical register map used for exception writes:
//     R0..R15 = 0..15 (PC = 15)
//     R14: FIQ 22, IRQ 24, SVC 26, ABT 28, UND 30
//     SPSR: FIQ 32, IRQ 33, SVC 34, ABT 35, UND 36
//
//   Ports
//     i_clk, i_reset                  clock, synchronous active-high reset
//     i_valid, i_flags                valid instruction and its CPSR result
//     i_code_stall                    fetch stalled; redirects are shelved
//     i_clear_alu/i_pc_alu            ALU branch
//     i_clear_dec/i_pc_dec            decode branch
//     i_thumb                         PC step 2 (Thumb) or 4 (ARM)
//     i_wr_index/i_wr_data            ALU result write
//     i_mem_load/i_wr_index_1/_data_1 load result write
//     i_exc                           {dabt,fiq,irq,iabt,swi,und}; MSB has priority
//     i_pc_buf, i_lr_data             LR sources for exception entry
//     i_hivec                         high-vector select
//     o_we0/o_wa0/o_wd0               write port 0
//     o_we1/o_wa1/o_wd1               write port 1 (constant 0 when NWP=1)
//     o_pc, o_pc_nxt, o_cpsr          architectural state
//     o_clear, o_stall, o_shelve      flush, busy, redirect-pending
module zap_writeback_mp #(
    parameter int          PHY_REGS   = 46,
    parameter int          NWP        = 2,
    parameter logic [31:0] RST_VEC    = 32'h0,
    parameter logic [31:0] HIVEC_BASE = 32'hFFFF0000,
    localparam int         IDXW       = $clog2(PHY_REGS)
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_valid,
    input  logic            i_code_stall,
    input  logic            i_clear_alu,
    input  logic [31:0]     i_pc_alu,
    input  logic            i_clear_dec,
    input  logic [31:0]     i_pc_dec,
    input  logic            i_thumb,
    input  logic [IDXW-1:0] i_wr_index,
    input  logic [31:0]     i_wr_data,
    input  logic            i_mem_load,
    input  logic [IDXW-1:0] i_wr_index_1,
    input  logic [31:0]     i_wr_data_1,
    input  logic [31:0]     i_flags,
    input  logic [5:0]      i_exc,
    input  logic [31:0]     i_pc_buf,
    input  logic [31:0]     i_lr_data,
    input  logic            i_hivec,
    output logic            o_we0,
    output logic [IDXW-1:0] o_wa0,
    output logic [31:0]     o_wd0,
    output logic            o_we1,
    output logic [IDXW-1:0] o_wa1,
    output logic [31:0]     o_wd1,
    output logic [31:0]     o_pc,
    output logic [31:0]     o_pc_nxt,
    output logic [31:0]     o_cpsr,
    output logic            o_clear,
    output logic            o_stall,
    output logic            o_shelve
);

    localparam logic [IDXW-1:0] IDX_PC       = IDXW'(15);
    localparam logic [IDXW-1:0] IDX_FIQ_R14  = IDXW'(22);
    localparam logic [IDXW-1:0] IDX_IRQ_R14  = IDXW'(24);
    localparam logic [IDXW-1:0] IDX_SVC_R14  = IDXW'(26);
    localparam logic [IDXW-1:0] IDX_ABT_R14  = IDXW'(28);
    localparam logic [IDXW-1:0] IDX_UND_R14  = IDXW'(30);
    localparam logic [IDXW-1:0] IDX_FIQ_SPSR = IDXW'(32);
    localparam logic [IDXW-1:0] IDX_IRQ_SPSR = IDXW'(33);
    localparam logic [IDXW-1:0] IDX_SVC_SPSR = IDXW'(34);
    localparam logic [IDXW-1:0] IDX_ABT_SPSR = IDXW'(35);
    localparam logic [IDXW-1:0] IDX_UND_SPSR = IDXW'(36);

    localparam logic [4:0] MODE_FIQ = 5'h11;
    localparam logic [4:0] MODE_IRQ = 5'h12;
    localparam logic [4:0] MODE_SVC = 5'h13;
    localparam logic [4:0] MODE_ABT = 5'h17;
    localparam logic [4:0] MODE_UND = 5'h1B;

    // SVC mode, I=1, F=1, T=0
    localparam logic [31:0] CPSR_RST = 32'h0000_00D3;

    typedef enum logic [1:0] {RUN, EXC2, LD2} state_t;

    state_t state, state_nxt;

    logic [31:0]     pc, cpsr, pc_raw, cpsr_n;
    logic            shelve, shelve_n;
    logic [31:0]     shelf_pc, shelf_n, redirect_pc;
    logic [31:0]     base, vec, lr;
    logic [4:0]      exc_mode;
    logic            exc_fiq, exc_any, is_dabt, thumb_state;
    logic [IDXW-1:0] exc_r14_idx, exc_spsr_idx;
    logic [IDXW-1:0] spsr_idx_q, ld_idx_q;
    logic [31:0]     spsr_q, ld_data_q;
    logic            ld_pc_run, ld_pc_ld2;

`ifdef ZAP_WB_HIVEC_EN
    assign base = i_hivec ? HIVEC_BASE : 32'h0;
`else
    localparam logic [31:0] HIVEC_BASE_unused = HIVEC_BASE;
    logic hivec_unused;
    assign hivec_unused = i_hivec;
    assign base         = 32'h0;
`endif

    assign exc_any     = |i_exc;
    assign is_dabt     = i_exc[5];
    assign thumb_state = cpsr[5];

    // Exception source decode, highest priority first.
    always_comb begin
        vec          = 32'h04;
        exc_mode     = MODE_UND;
        exc_r14_idx  = IDX_UND_R14;
        exc_spsr_idx = IDX_UND_SPSR;
        exc_fiq      = 1'b0;
        if (i_exc[5]) begin
            vec = 32'h10; exc_mode = MODE_ABT;
            exc_r14_idx = IDX_ABT_R14; exc_spsr_idx = IDX_ABT_SPSR;
        end else if (i_exc[4]) begin
            vec = 32'h1C; exc_mode = MODE_FIQ; exc_fiq = 1'b1;
            exc_r14_idx = IDX_FIQ_R14; exc_spsr_idx = IDX_FIQ_SPSR;
        end else if (i_exc[3]) begin
            vec = 32'h18; exc_mode = MODE_IRQ;
            exc_r14_idx = IDX_IRQ_R14; exc_spsr_idx = IDX_IRQ_SPSR;
        end else if (i_exc[2]) begin
            vec = 32'h0C; exc_mode = MODE_ABT;
            exc_r14_idx = IDX_ABT_R14; exc_spsr_idx = IDX_ABT_SPSR;
        end else if (i_exc[1]) begin
            vec = 32'h08; exc_mode = MODE_SVC;
            exc_r14_idx = IDX_SVC_R14; exc_spsr_idx = IDX_SVC_SPSR;
        end
    end

    // Data aborts return to PC+8 in ARM; in Thumb the buffered PC is 4 short.
    assign lr = is_dabt ? (i_pc_buf + (thumb_state ? 32'd4 : 32'd0))
                        : (thumb_state ? i_pc_buf : i_lr_data);

    // With NWP=1 a load to PC redirects from LD2 instead of from RUN.
    assign ld_pc_run = (state == RUN) && !exc_any && i_valid && i_mem_load &&
                       (i_wr_index_1 == IDX_PC) && (NWP == 2);
    assign ld_pc_ld2 = (state == LD2) && (ld_idx_q == IDX_PC);

    // State register
    always_ff @(posedge i_clk) begin
        if (i_reset) state <= RUN;
        else         state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            RUN: begin
                if (NWP == 1) begin
                    if (exc_any)                    state_nxt = EXC2;
                    else if (i_valid && i_mem_load) state_nxt = LD2;
                end
            end
            EXC2:    state_nxt = RUN;
            LD2:     state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end

    // Output logic; a reset cycle suppresses every write, flush and stall.
    always_comb begin
        o_we0   = 1'b0;
        o_wa0   = '0;
        o_wd0   = '0;
        o_we1   = 1'b0;
        o_wa1   = '0;
        o_wd1   = '0;
        o_clear = 1'b0;
        o_stall = 1'b0;
        case (state)
            RUN: begin
                if (exc_any) begin
                    o_we0   = 1'b1;
                    o_wa0   = exc_r14_idx;
                    o_wd0   = lr;
                    o_clear = 1'b1;
                    if (NWP == 2) begin
                        o_we1 = 1'b1;
                        o_wa1 = exc_spsr_idx;
                        o_wd1 = cpsr;
                    end
                end else if (i_valid) begin
                    o_we0   = 1'b1;
                    o_wa0   = i_wr_index;
                    o_wd0   = i_wr_data;
                    o_clear = ld_pc_run;
                    if (NWP == 2 && i_mem_load) begin
                        o_we1 = 1'b1;
                        o_wa1 = i_wr_index_1;
                        o_wd1 = i_wr_data_1;
                    end
                end
            end
            EXC2: begin
                o_we0   = 1'b1;
                o_wa0   = spsr_idx_q;
                o_wd0   = spsr_q;
                o_stall = 1'b1;
            end
            LD2: begin
                o_we0   = 1'b1;
                o_wa0   = ld_idx_q;
                o_wd0   = ld_data_q;
                o_stall = 1'b1;
                o_clear = ld_pc_ld2;
            end
            default: ;
        endcase
        if (i_reset) begin
            o_we0   = 1'b0;
            o_we1   = 1'b0;
            o_clear = 1'b0;
            o_stall = 1'b0;
        end
    end

    // PC / CPSR / shelve next values.
    always_comb begin
        pc_raw      = pc;
        cpsr_n      = cpsr;
        shelve_n    = shelve;
        shelf_n     = shelf_pc;
        redirect_pc = i_clear_alu ? i_pc_alu : i_pc_dec;
        if (state == RUN) begin
            if (exc_any) begin
                pc_raw   = base + vec;
                shelve_n = 1'b0;
                cpsr_n   = {cpsr[31:8], 1'b1, (exc_fiq | cpsr[6]), 1'b0, exc_mode};
            end else begin
                if (i_valid) cpsr_n = i_flags;
                if (ld_pc_run) begin
                    pc_raw   = i_wr_data_1;
                    shelve_n = 1'b0;
                end else if (i_clear_alu || i_clear_dec) begin
                    // Fetch cannot take the redirect yet: park it (newest wins).
                    if (i_code_stall) begin
                        shelve_n = 1'b1;
                        shelf_n  = redirect_pc;
                    end else begin
                        pc_raw   = redirect_pc;
                        shelve_n = 1'b0;
                    end
                end else if (i_code_stall) begin
                    pc_raw = pc;
                end else if (shelve) begin
                    pc_raw   = shelf_pc;
                    shelve_n = 1'b0;
                end else begin
                    pc_raw = pc + (i_thumb ? 32'd2 : 32'd4);
                end
            end
        end else if (ld_pc_ld2) begin
            pc_raw   = ld_data_q;
            shelve_n = 1'b0;
        end
    end

    assign o_pc_nxt = {pc_raw[31:1], 1'b0};

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            pc         <= RST_VEC;
            cpsr       <= CPSR_RST;
            shelve     <= 1'b0;
            shelf_pc   <= '0;
            spsr_q     <= '0;
            spsr_idx_q <= '0;
            ld_idx_q   <= '0;
            ld_data_q  <= '0;
        end else begin
            pc       <= o_pc_nxt;
            cpsr     <= cpsr_n;
            shelve   <= shelve_n;
            shelf_pc <= shelf_n;
            // Second-write payloads are captured on every RUN cycle; only the
            // one captured on the transition into EXC2/LD2 is ever consumed.
            if (state == RUN) begin
                spsr_q     <= cpsr;
                spsr_idx_q <= exc_spsr_idx;
                ld_idx_q   <= i_wr_index_1;
                ld_data_q  <= i_wr_data_1;
            end
        end
    end

    assign o_pc     = pc;
    assign o_cpsr   = cpsr;
    assign o_shelve = shelve;

endmodule

// File: tb/tb_zap_writeback_mp.sv
// tb_zap_writeback_mp
//   Directed bench for zap_writeback_mp. Two instances (NWP=2 as "a", NWP=1
//   as "b") share one set of inputs. Expected values are queued as each cycle's
//   stimulus is driven and compared at the following negative clock edge.
module tb_zap_writeback_mp;

    localparam int PC = 0, NXT = 1, CPSR = 2, CLR = 3, STL = 4, SHV = 5;
    localparam int WE0 = 6, WA0 = 7, WD0 = 8, WE1 = 9, WA1 = 10, WD1 = 11;
    localparam int B = 16;

`ifdef ZAP_WB_HIVEC_EN
    localparam logic [31:0] SWI_VEC = 32'hFFFF_0008;
`else
    localparam logic [31:0] SWI_VEC = 32'h0000_0008;
`endif

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, valid, code_stall, clear_alu, clear_dec, thumb, mem_load, hivec;
    logic [31:0] pc_alu, pc_dec, wr_data, wr_data_1, flags, pc_buf, lr_data;
    logic [5:0]  wr_index, wr_index_1, exc;

    logic        we0_a, we1_a, clear_a, stall_a, shelve_a;
    logic [5:0]  wa0_a, wa1_a;
    logic [31:0] wd0_a, wd1_a, pc_a, pc_nxt_a, cpsr_a;
    logic        we0_b, we1_b, clear_b, stall_b, shelve_b;
    logic [5:0]  wa0_b, wa1_b;
    logic [31:0] wd0_b, wd1_b, pc_b, pc_nxt_b, cpsr_b;

    zap_writeback_mp #(.NWP(2)) dut_a (
        .i_clk(clk), .i_reset(reset), .i_valid(valid), .i_code_stall(code_stall),
        .i_clear_alu(clear_alu), .i_pc_alu(pc_alu), .i_clear_dec(clear_dec),
        .i_pc_dec(pc_dec), .i_thumb(thumb), .i_wr_index(wr_index),
        .i_wr_data(wr_data), .i_mem_load(mem_load), .i_wr_index_1(wr_index_1),
        .i_wr_data_1(wr_data_1), .i_flags(flags), .i_exc(exc), .i_pc_buf(pc_buf),
        .i_lr_data(lr_data), .i_hivec(hivec),
        .o_we0(we0_a), .o_wa0(wa0_a), .o_wd0(wd0_a),
        .o_we1(we1_a), .o_wa1(wa1_a), .o_wd1(wd1_a),
        .o_pc(pc_a), .o_pc_nxt(pc_nxt_a), .o_cpsr(cpsr_a),
        .o_clear(clear_a), .o_stall(stall_a), .o_shelve(shelve_a)
    );

    zap_writeback_mp #(.NWP(1)) dut_b (
        .i_clk(clk), .i_reset(reset), .i_valid(valid), .i_code_stall(code_stall),
        .i_clear_alu(clear_alu), .i_pc_alu(pc_alu), .i_clear_dec(clear_dec),
        .i_pc_dec(pc_dec), .i_thumb(thumb), .i_wr_index(wr_index),
        .i_wr_data(wr_data), .i_mem_load(mem_load), .i_wr_index_1(wr_index_1),
        .i_wr_data_1(wr_data_1), .i_flags(flags), .i_exc(exc), .i_pc_buf(pc_buf),
        .i_lr_data(lr_data), .i_hivec(hivec),
        .o_we0(we0_b), .o_wa0(wa0_b), .o_wd0(wd0_b),
        .o_we1(we1_b), .o_wa1(wa1_b), .o_wd1(wd1_b),
        .o_pc(pc_b), .o_pc_nxt(pc_nxt_b), .o_cpsr(cpsr_b),
        .o_clear(clear_b), .o_stall(stall_b), .o_shelve(shelve_b)
    );

    typedef struct {
        string       tag;
        int          sig;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    function automatic logic [31:0] obs(int s);
        case (s)
            PC:      return pc_a;
            NXT:     return pc_nxt_a;
            CPSR:    return cpsr_a;
            CLR:     return {31'b0, clear_a};
            STL:     return {31'b0, stall_a};
            SHV:     return {31'b0, shelve_a};
            WE0:     return {31'b0, we0_a};
            WA0:     return {26'b0, wa0_a};
            WD0:     return wd0_a;
            WE1:     return {31'b0, we1_a};
            WA1:     return {26'b0, wa1_a};
            WD1:     return wd1_a;
            B+PC:    return pc_b;
            B+NXT:   return pc_nxt_b;
            B+CPSR:  return cpsr_b;
            B+CLR:   return {31'b0, clear_b};
            B+STL:   return {31'b0, stall_b};
            B+SHV:   return {31'b0, shelve_b};
            B+WE0:   return {31'b0, we0_b};
            B+WA0:   return {26'b0, wa0_b};
            B+WD0:   return wd0_b;
            B+WE1:   return {31'b0, we1_b};
            B+WA1:   return {26'b0, wa1_b};
            B+WD1:   return wd1_b;
            default: return 'x;
        endcase
    endfunction

    task automatic exp_a(input string t, input int s, input logic [31:0] v);
        sb.push_back('{{t, "/a"}, s, v});
    endtask

    task automatic exp_b(input string t, input int s, input logic [31:0] v);
        sb.push_back('{{t, "/b"}, s + B, v});
    endtask

    task automatic exp2(input string t, input int s, input logic [31:0] v);
        exp_a(t, s, v);
        exp_b(t, s, v);
    endtask

    // Compare everything queued for this cycle, then advance one clock.
    task automatic cyc();
        exp_t        e;
        logic [31:0] o;
        @(negedge clk);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            o = obs(e.sig);
            checks++;
            assert (o === e.exp) else begin
                failures++;
                $error("FAIL %s observed=%h expected=%h", e.tag, o, e.exp);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        valid = 0; code_stall = 0; clear_alu = 0; clear_dec = 0; thumb = 0;
        mem_load = 0; hivec = 0; pc_alu = 0; pc_dec = 0; wr_data = 0;
        wr_data_1 = 0; flags = 0; pc_buf = 0; lr_data = 0; wr_index = 0;
        wr_index_1 = 0; exc = 0;
    endtask

    initial begin
        reset = 1;
        idle();
        @(posedge clk);
        #1;

        // Reset state
        exp2("rst_pc", PC, 32'h0);       exp2("rst_cpsr", CPSR, 32'hD3);
        exp2("rst_we0", WE0, 0);         exp2("rst_clear", CLR, 0);
        exp2("rst_stall", STL, 0);       exp2("rst_shelve", SHV, 0);
        exp_a("rst_we1", WE1, 0);
        cyc();
        reset = 0;

        // Sequential ARM fetch
        exp2("seq_pc0", PC, 32'h0); exp2("seq_nxt0", NXT, 32'h4); cyc();
        exp2("seq_pc1", PC, 32'h4); cyc();
        exp2("seq_pc2", PC, 32'h8); cyc();

        // Redirect raised under fetch stall is shelved
        code_stall = 1; clear_alu = 1; pc_alu = 32'h100;
        exp2("seq_pc3", PC, 32'hC); exp2("seq_cpsr", CPSR, 32'hD3);
        exp2("shv_hold", NXT, 32'hC); exp2("shv_not_yet", SHV, 0);
        cyc();
        clear_alu = 0;
        exp2("shv_set", SHV, 1); exp2("shv_pc_hold", PC, 32'hC); exp2("shv_nxt_hold", NXT, 32'hC);
        cyc();
        code_stall = 0;
        exp2("shv_pend", SHV, 1); exp2("shv_apply", NXT, 32'h100);
        cyc();

        // Valid ALU write; CPSR picks up Thumb, USR
        valid = 1; wr_index = 3; wr_data = 32'hAA; flags = 32'h30;
        exp2("alu_pc", PC, 32'h100); exp2("alu_shv_clr", SHV, 0); exp2("alu_nxt", NXT, 32'h104);
        exp2("alu_we0", WE0, 1); exp2("alu_wa0", WA0, 3); exp2("alu_wd0", WD0, 32'hAA);
        exp2("alu_clear", CLR, 0); exp_a("alu_we1", WE1, 0);
        cyc();
        idle();

        // Data abort in Thumb beats a valid instruction
        exc = 6'b100000; pc_buf = 32'h208; lr_data = 32'hDEAD;
        valid = 1; wr_index = 5; wr_data = 32'h55;
        exp2("dabt_pc", PC, 32'h104); exp2("dabt_nxt", NXT, 32'h10); exp2("dabt_clear", CLR, 1);
        exp2("dabt_we0", WE0, 1); exp2("dabt_wa0", WA0, 28); exp2("dabt_lr", WD0, 32'h20C);
        exp_a("dabt_we1", WE1, 1); exp_a("dabt_wa1", WA1, 35); exp_a("dabt_spsr", WD1, 32'h30);
        exp_b("dabt_we1", WE1, 0); exp_b("dabt_stall", STL, 0);
        cyc();
        idle();
        exp2("dabt2_pc", PC, 32'h10); exp2("dabt2_cpsr", CPSR, 32'h97);
        exp_a("dabt2_nxt", NXT, 32'h14); exp_a("dabt2_stall", STL, 0); exp_a("dabt2_we0", WE0, 0);
        exp_b("exc2_stall", STL, 1); exp_b("exc2_we0", WE0, 1); exp_b("exc2_wa0", WA0, 35);
        exp_b("exc2_spsr", WD0, 32'h30); exp_b("exc2_hold", NXT, 32'h10); exp_b("exc2_clear", CLR, 0);
        cyc();

        // IRQ with a lower-priority UND also raised
        exc = 6'b001001; lr_data = 32'h44; pc_buf = 32'h999;
        exp_a("irq_pc", PC, 32'h14); exp_b("irq_pc", PC, 32'h10); exp_b("irq_run", STL, 0);
        exp2("irq_nxt", NXT, 32'h18); exp2("irq_clear", CLR, 1);
        exp2("irq_we0", WE0, 1); exp2("irq_wa0", WA0, 24); exp2("irq_lr", WD0, 32'h44);
        exp_a("irq_we1", WE1, 1); exp_a("irq_wa1", WA1, 33); exp_a("irq_spsr", WD1, 32'h97);
        cyc();
        idle();
        exp2("irq2_pc", PC, 32'h18); exp2("irq2_cpsr", CPSR, 32'h92);
        exp_a("irq2_stall", STL, 0); exp_a("irq2_we0", WE0, 0);
        exp_b("irq2_stall", STL, 1); exp_b("irq2_we0", WE0, 1); exp_b("irq2_wa0", WA0, 33);
        exp_b("irq2_spsr", WD0, 32'h97); exp_b("irq2_hold", NXT, 32'h18);
        cyc();
        exp_a("irq3_pc", PC, 32'h1C);
        exp_b("irq3_pc", PC, 32'h18); exp_b("irq3_run", STL, 0);
        exp_b("irq3_we0", WE0, 0); exp_b("irq3_nxt", NXT, 32'h1C);
        cyc();

        // Load to PC alongside an ALU write
        valid = 1; wr_index = 2; wr_data = 32'h77; mem_load = 1;
        wr_index_1 = 15; wr_data_1 = 32'h301; flags = 32'h1F;
        exp_a("ld_pc", PC, 32'h20); exp_a("ld_nxt", NXT, 32'h300); exp_a("ld_clear", CLR, 1);
        exp_a("ld_we1", WE1, 1); exp_a("ld_wa1", WA1, 15); exp_a("ld_wd1", WD1, 32'h301);
        exp_b("ld_pc", PC, 32'h1C); exp_b("ld_nxt", NXT, 32'h20); exp_b("ld_clear", CLR, 0);
        exp_b("ld_we1", WE1, 0);
        exp2("ld_we0", WE0, 1); exp2("ld_wa0", WA0, 2); exp2("ld_wd0", WD0, 32'h77);
        cyc();
        idle();
        exp_a("ld2_pc", PC, 32'h300); exp_a("ld2_nxt", NXT, 32'h304);
        exp_a("ld2_clear", CLR, 0); exp_a("ld2_we0", WE0, 0);
        exp_b("ld2_pc", PC, 32'h20); exp_b("ld2_stall", STL, 1); exp_b("ld2_clear", CLR, 1);
        exp_b("ld2_nxt", NXT, 32'h300); exp_b("ld2_we0", WE0, 1); exp_b("ld2_wa0", WA0, 15);
        exp_b("ld2_wd0", WD0, 32'h301); exp2("ld2_cpsr", CPSR, 32'h1F);
        cyc();
        exp_a("ld3_pc", PC, 32'h304);
        exp_b("ld3_pc", PC, 32'h300); exp_b("ld3_run", STL, 0); exp_b("ld3_nxt", NXT, 32'h304);
        cyc();

        // SWI with high vectors requested
        exc = 6'b000010; hivec = 1; lr_data = 32'h1234;
        exp2("swi_nxt", NXT, SWI_VEC); exp2("swi_clear", CLR, 1);
        exp2("swi_wa0", WA0, 26); exp2("swi_lr", WD0, 32'h1234);
        exp_a("swi_wa1", WA1, 34); exp_a("swi_spsr", WD1, 32'h1F);
        cyc();
        idle();
        exp2("swi2_pc", PC, SWI_VEC); exp2("swi2_cpsr", CPSR, 32'h93);
        cyc();

        // FIQ sets F
        exc = 6'b010000; lr_data = 32'h5678;
        exp2("fiq_nxt", NXT, 32'h1C); exp2("fiq_wa0", WA0, 22); exp2("fiq_lr", WD0, 32'h5678);
        exp_a("fiq_wa1", WA1, 32); exp_a("fiq_spsr", WD1, 32'h93);
        cyc();
        idle();

        // Reset while the NWP=1 instance is in EXC2 drops the SPSR write
        reset = 1;
        exp2("fiq2_pc", PC, 32'h1C); exp2("fiq2_cpsr", CPSR, 32'hD1);
        exp_b("rst_exc2_we0", WE0, 0); exp_b("rst_exc2_stall", STL, 0);
        exp2("rst_exc2_clear", CLR, 0);
        cyc();
        reset = 0;

        // Newer shelved redirect overwrites the older one; then Thumb step
        code_stall = 1; clear_alu = 1; pc_alu = 32'h400;
        exp2("rst2_pc", PC, 32'h0); exp2("rst2_cpsr", CPSR, 32'hD3); exp2("ovr_hold", NXT, 32'h0);
        cyc();
        clear_alu = 0; clear_dec = 1; pc_dec = 32'h500;
        exp2("ovr_shv", SHV, 1); exp2("ovr_hold2", NXT, 32'h0); exp2("ovr_pc", PC, 32'h0);
        cyc();
        idle();
        exp2("ovr_pend", SHV, 1); exp2("ovr_apply", NXT, 32'h500);
        cyc();
        thumb = 1;
        exp2("thumb_pc", PC, 32'h500); exp2("thumb_shv", SHV, 0); exp2("thumb_nxt", NXT, 32'h502);
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
